// File: rtl/rgb_fade_pkg.sv
// Shared sector encoding and default parameters for the RGB fade sequencer.
package rgb_fade_pkg;

  localparam int PWM_BITS_DEFAULT = 8;
  localparam int STEP_DIV_DEFAULT = 7812;

  typedef enum logic [2:0] {
    SEC_0 = 3'd0,
    SEC_1 = 3'd1,
    SEC_2 = 3'd2,
    SEC_3 = 3'd3,
    SEC_4 = 3'd4,
    SEC_5 = 3'd5
  } sector_t;

  // Codes 6 and 7 fall into the default arm so a corrupted sector recovers to SEC_0.
  function automatic sector_t next_sector(input sector_t s);
    case (s)
      SEC_0:   return SEC_1;
      SEC_1:   return SEC_2;
      SEC_2:   return SEC_3;
      SEC_3:   return SEC_4;
      SEC_4:   return SEC_5;
      default: return SEC_0;
    endcase
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_pwm_channel.sv
// One PWM output channel: duty shadow register plus registered active-low comparator.
module pwm_channel
  import rgb_fade_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pad
);

  logic [PWM_BITS-1:0] shadow;

  // The shadow only reloads on the last count so a period never mixes two duties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      pad    <= 1'b1;
    end else begin
      if (pwm_cnt == {PWM_BITS{1'b1}}) begin
        shadow <= duty;
      end
      pad <= ~(pwm_cnt < shadow);
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Hue-wheel RGB fader: prescaled ramp through six sectors driving three PWM pads.
// Optional macro FADE_GAMMA_EN squares each duty ((v*v)>>PWM_BITS) before registering it.
module rgb_fade_sequencer
  import rgb_fade_pkg::*;
#(
  parameter int STEP_DIV = STEP_DIV_DEFAULT,
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B,
  output logic [PWM_BITS-1:0] duty_r,
  output logic [PWM_BITS-1:0] duty_g,
  output logic [PWM_BITS-1:0] duty_b,
  output logic [2:0]          sector,
  output logic                cycle_done
);

  localparam int                 PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  sector_t             sector_q, sector_d;
  logic                cycle_done_d;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] r_v, g_v, b_v;

  function automatic logic [PWM_BITS-1:0] shape(input logic [PWM_BITS-1:0] v);
`ifdef FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, v} * {{PWM_BITS{1'b0}}, v};
    return sq[2*PWM_BITS-1:PWM_BITS];
`else
    return v;
`endif
  endfunction

  assign tick   = en && (presc_q == PRE_LAST);
  assign sector = sector_q;

  // Prescaler freezes (not clears) while disabled so a resume costs no extra tick.
  always_comb begin
    presc_d      = presc_q;
    ramp_d       = ramp_q;
    sector_d     = sector_q;
    cycle_done_d = 1'b0;
    if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    if (tick) begin
      ramp_d = ramp_q + 1'b1;
      if ((ramp_q == MAX) || (sector_q > SEC_5)) begin
        sector_d = next_sector(sector_q);
      end
      cycle_done_d = (ramp_q == MAX) && (sector_q == SEC_5);
    end
  end

  always_comb begin
    r_v = '0;
    g_v = '0;
    b_v = '0;
    case (sector_q)
      SEC_0: begin r_v = MAX;          g_v = ramp_q;       end
      SEC_1: begin r_v = MAX - ramp_q; g_v = MAX;          end
      SEC_2: begin g_v = MAX;          b_v = ramp_q;       end
      SEC_3: begin g_v = MAX - ramp_q; b_v = MAX;          end
      SEC_4: begin r_v = ramp_q;       b_v = MAX;          end
      SEC_5: begin r_v = MAX;          b_v = MAX - ramp_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      ramp_q     <= '0;
      sector_q   <= SEC_0;
      pwm_cnt    <= '0;
      duty_r     <= MAX;
      duty_g     <= '0;
      duty_b     <= '0;
      cycle_done <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      ramp_q     <= ramp_d;
      sector_q   <= sector_d;
      pwm_cnt    <= pwm_cnt + 1'b1;
      duty_r     <= shape(r_v);
      duty_g     <= shape(g_v);
      duty_b     <= shape(b_v);
      cycle_done <= cycle_done_d;
    end
  end

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_r (
    .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt), .duty(duty_r), .pad(RGB_R)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_g (
    .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt), .duty(duty_g), .pad(RGB_G)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_b (
    .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt), .duty(duty_b), .pad(RGB_B)
  );

endmodule
